pc_next_sel: RTL and testbench
==============================

PC_NEXT_SEL -- requirements
Module: pc_next_sel

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the PC and target width in bits.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0040_0000, meaning the PC value loaded on reset.
REQ-003 The block SHALL have parameter INC, default 4, meaning the sequential PC increment.
REQ-004 The block SHALL have port clk, input, width 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, width 1; reset is asynchronous and active-high.
REQ-006 The block SHALL have port stall, input, width 1; when 1 the PC holds.
REQ-007 The block SHALL have port jump, input, width 1, plus jump_tgt, input, width WIDTH: jump request and its target.
REQ-008 The block SHALL have port branch, input, width 1, plus br_tgt, input, width WIDTH: taken-branch request and its target.
REQ-009 The block SHALL have port exc, input, width 1, plus exc_vec, input, width WIDTH: exception request and its vector.
REQ-010 The block SHALL have port pc, output, width WIDTH, the registered current PC.
REQ-011 The block SHALL have port pc_plus, output, width WIDTH, the combinational value pc + INC.
REQ-012 The block SHALL have port src, output, width 2, registered code of the source last loaded into pc: 00 seq, 01 jump, 10 branch, 11 exception.
REQ-013 The block SHALL have port redirected, output, width 1, a registered one-cycle pulse.
REQ-014 The block SHALL have port pend_valid, output, width 1, set while a redirect is buffered.

Function
REQ-015 Request rank SHALL be exc=3, branch=2, jump=1, none=0; the live request is the highest-ranked asserted one (branch beats jump when both are set).
REQ-016 pc_plus SHALL be (pc + INC) modulo 2^WIDTH; wrap from all-ones carries no flag.
REQ-017 On a cycle with stall=0 and no live request and pend_valid=0, pc SHALL load pc_plus and src SHALL load 00.
REQ-018 On a cycle with stall=0, if live rank > pending rank, pc SHALL load the live target and src its code; otherwise, if pend_valid=1, pc SHALL load pend_tgt and src the pending code.
REQ-019 On every stall=0 cycle, pend_valid SHALL clear.
REQ-020 On a cycle with stall=1, pc and src SHALL hold.
REQ-021 On a stall=1 cycle with a live request, the buffer SHALL capture the target and rank if pend_valid=0 or live rank >= pending rank; otherwise it SHALL hold. pend_valid SHALL set when the buffer captures.
REQ-022 redirected SHALL be 1 in the cycle after pc loads a non-sequential target, and 0 otherwise, including during stalls.
REQ-023 Targets SHALL be loaded unmodified; alignment checking is outside this block.
REQ-024 Latency SHALL be one cycle from an unstalled request to the new pc value.

Reset
REQ-025 While rst=1, the block SHALL force pc=RESET_PC, src=00, redirected=0, pend_valid=0, the pending target to 0 and the pending rank to 0, regardless of clk.
REQ-026 Reset asserted mid-stall SHALL discard any buffered redirect; the first edge after release with stall=0 and no request SHALL load RESET_PC+INC.

Verification
REQ-027 Sequential run: reset, then 3 unstalled idle cycles -> pc 0x00400004, 0x00400008, 0x0040000C; src=00; redirected=0.
REQ-028 Priority: pc=0x00400010, jump=1 with jump_tgt=0x00400100, and branch=1 with br_tgt=0x00400200, same cycle -> pc=0x00400200, src=10, redirected=1 for one cycle.
REQ-029 Buffered upgrade: stall=1; jump to 0x00400100, then next cycle exc with vector 0x80000180, then stall=0 -> pc=0x80000180, src=11, pend_valid returns 0.
REQ-030 Buffer holds: stall=1; exc to 0x80000180, then next cycle branch to 0x00400300, then release -> pc=0x80000180.
REQ-031 Live beats buffer: pending jump 0x00400100; on the release cycle branch=1 to 0x00400400 -> pc=0x00400400, src=10.
REQ-032 Wrap and reset: WIDTH=32, pc=0xFFFFFFFC, idle cycle -> pc=0x00000000; assert rst asynchronously mid-stall with pend_valid=1 -> pc=0x00400000 and pend_valid=0 immediately.

Source files
------------

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential increment, ranked jump/branch/exception
// redirects, and a one-entry buffer that holds the strongest redirect seen while stalled.
module pc_next_sel #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0040_0000,
  parameter int               INC      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_tgt,
  input  logic             branch,
  input  logic [WIDTH-1:0] br_tgt,
  input  logic             exc,
  input  logic [WIDTH-1:0] exc_vec,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [1:0]       src,
  output logic             redirected,
  output logic             pend_valid
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  // The rank of a request doubles as its src code (jump=01, branch=10, exc=11).
  function automatic logic [1:0] req_rank(input logic e, input logic b, input logic j);
    logic [1:0] r;
    if (e) begin
      r = 2'b11;
    end else if (b) begin
      r = 2'b10;
    end else if (j) begin
      r = 2'b01;
    end else begin
      r = 2'b00;
    end
    return r;
  endfunction

  logic [WIDTH-1:0] pc_r;
  logic [1:0]       src_r;
  logic             redirected_r;
  logic             pend_valid_r;
  logic [WIDTH-1:0] pend_tgt_r;
  logic [1:0]       pend_rank_r;

  logic [1:0]       live_rank_s;
  logic [WIDTH-1:0] live_tgt_s;
  logic [1:0]       pend_rank_eff_s;
  logic [WIDTH-1:0] pc_plus_s;

  logic [WIDTH-1:0] pc_s;
  logic [1:0]       src_s;
  logic             redirected_s;
  logic             pend_valid_s;
  logic [WIDTH-1:0] pend_tgt_s;
  logic [1:0]       pend_rank_s;

  assign pc_plus_s = pc_r + INC_W;

  // Select the highest-ranked live request and its target.
  always_comb begin
    live_rank_s = req_rank(exc, branch, jump);
    live_tgt_s  = {WIDTH{1'b0}};
    case (live_rank_s)
      2'b11:   live_tgt_s = exc_vec;
      2'b10:   live_tgt_s = br_tgt;
      2'b01:   live_tgt_s = jump_tgt;
      default: live_tgt_s = {WIDTH{1'b0}};
    endcase
  end

  // An empty buffer competes with rank 0 so any live request beats it.
  always_comb begin
    if (pend_valid_r) begin
      pend_rank_eff_s = pend_rank_r;
    end else begin
      pend_rank_eff_s = 2'b00;
    end
  end

  // Next-state selection for the PC, source code, pulse and redirect buffer.
  always_comb begin
    pc_s         = pc_r;
    src_s        = src_r;
    redirected_s = 1'b0;
    pend_valid_s = pend_valid_r;
    pend_tgt_s   = pend_tgt_r;
    pend_rank_s  = pend_rank_r;
    if (!stall) begin
      pend_valid_s = 1'b0;
      pend_rank_s  = 2'b00;
      if (live_rank_s > pend_rank_eff_s) begin
        pc_s         = live_tgt_s;
        src_s        = live_rank_s;
        redirected_s = 1'b1;
      end else if (pend_valid_r) begin
        pc_s         = pend_tgt_r;
        src_s        = pend_rank_r;
        redirected_s = 1'b1;
      end else begin
        pc_s         = pc_plus_s;
        src_s        = 2'b00;
        redirected_s = 1'b0;
      end
    end else begin
      // Equal rank overwrites, so the newest redirect of a given kind wins.
      if ((live_rank_s != 2'b00) && (!pend_valid_r || (live_rank_s >= pend_rank_r))) begin
        pend_valid_s = 1'b1;
        pend_tgt_s   = live_tgt_s;
        pend_rank_s  = live_rank_s;
      end else begin
        pend_valid_s = pend_valid_r;
        pend_tgt_s   = pend_tgt_r;
        pend_rank_s  = pend_rank_r;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r         <= RESET_PC;
      src_r        <= 2'b00;
      redirected_r <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_tgt_r   <= {WIDTH{1'b0}};
      pend_rank_r  <= 2'b00;
    end else begin
      pc_r         <= pc_s;
      src_r        <= src_s;
      redirected_r <= redirected_s;
      pend_valid_r <= pend_valid_s;
      pend_tgt_r   <= pend_tgt_s;
      pend_rank_r  <= pend_rank_s;
    end
  end

  assign pc         = pc_r;
  assign pc_plus    = pc_plus_s;
  assign src        = src_r;
  assign redirected = redirected_r;
  assign pend_valid = pend_valid_r;

endmodule

// File: tb/tb_pc_next_sel.sv
// Randomized bench for pc_next_sel against a queue-based reference model,
// preceded by directed scenarios for priority, buffering, wrap and reset.
module tb_pc_next_sel;
  localparam int          WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int          INC      = 4;

  logic        clk = 1'b0;
  logic        rst, stall, jump, branch, exc;
  logic [31:0] jump_tgt, br_tgt, exc_vec, pc, pc_plus;
  logic [1:0]  src;
  logic        redirected, pend_valid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          rank;
    logic [31:0] tgt;
  } pend_t;

  logic [31:0] m_pc;
  logic [1:0]  m_src;
  logic        m_redir;
  pend_t       m_pend[$];

  pc_next_sel #(.WIDTH(WIDTH), .RESET_PC(RESET_PC), .INC(INC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .jump(jump), .jump_tgt(jump_tgt),
    .branch(branch), .br_tgt(br_tgt),
    .exc(exc), .exc_vec(exc_vec),
    .pc(pc), .pc_plus(pc_plus), .src(src),
    .redirected(redirected), .pend_valid(pend_valid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int rank_now();
    return exc ? 3 : (branch ? 2 : (jump ? 1 : 0));
  endfunction

  function automatic logic [31:0] tgt_for(input int r);
    case (r)
      3:       return exc_vec;
      2:       return br_tgt;
      1:       return jump_tgt;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_src   = 2'b00;
    m_redir = 1'b0;
    m_pend.delete();
  endtask

  task automatic model_step();
    int lr;
    int pr;
    pend_t p;
    lr = rank_now();
    pr = (m_pend.size() != 0) ? m_pend[0].rank : 0;
    if (!stall) begin
      if (lr > pr) begin
        m_pc = tgt_for(lr); m_src = 2'(lr); m_redir = 1'b1;
      end else if (m_pend.size() != 0) begin
        m_pc = m_pend[0].tgt; m_src = 2'(pr); m_redir = 1'b1;
      end else begin
        m_pc = 32'(m_pc + 32'(INC)); m_src = 2'b00; m_redir = 1'b0;
      end
      m_pend.delete();
    end else begin
      m_redir = 1'b0;
      if (lr > 0 && (m_pend.size() == 0 || lr >= pr)) begin
        p.rank = lr;
        p.tgt  = tgt_for(lr);
        m_pend.delete();
        m_pend.push_back(p);
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".pc"},      pc,         m_pc);
    check_val({tag, ".pc_plus"}, pc_plus,    32'(m_pc + 32'(INC)));
    check_val({tag, ".src"},     {30'b0, src},        {30'b0, m_src});
    check_val({tag, ".redir"},   {31'b0, redirected}, {31'b0, m_redir});
    check_val({tag, ".pvalid"},  {31'b0, pend_valid}, {31'b0, (m_pend.size() != 0)});
  endtask

  task automatic drive(input logic s, input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt,
                       input logic e, input logic [31:0] ev);
    stall = s; jump = j; jump_tgt = jt; branch = b; br_tgt = bt; exc = e; exc_vec = ev;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // Sequential run
    step("seq1"); check_val("seq1.abs", pc, 32'h0040_0004);
    step("seq2"); check_val("seq2.abs", pc, 32'h0040_0008);
    step("seq3"); check_val("seq3.abs", pc, 32'h0040_000C);
    step("seq4"); check_val("seq4.abs", pc, 32'h0040_0010);

    // Branch beats jump in the same cycle
    drive(1'b0, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
    step("prio");
    check_val("prio.abs", pc, 32'h0040_0200);
    check_val("prio.src", {30'b0, src}, 32'h2);
    check_val("prio.redir", {31'b0, redirected}, 32'h1);
    idle();
    step("prio_after");
    check_val("prio_after.redir", {31'b0, redirected}, 32'h0);

    // Buffered upgrade: jump then exception while stalled
    drive(1'b1, 1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b0, 32'h0);
    step("upg1");
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_0180);
    step("upg2");
    idle();
    step("upg3");
    check_val("upg.abs", pc, 32'h8000_0180);
    check_val("upg.src", {30'b0, src}, 32'h3);
    check_val("upg.pvalid", {31'b0, pend_valid}, 32'h0);

    // Buffer holds a stronger exception against a later branch
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_0180);
    step("hold1");
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0300, 1'b0, 32'h0);
    step("hold2");
    idle();
    step("hold3");
    check_val("hold.abs", pc, 32'h8000_0180);

    // Live branch on the release cycle beats the buffered jump
    drive(1'b1, 1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b0, 32'h0);
    step("live1");
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0400, 1'b0, 32'h0);
    step("live2");
    check_val("live.abs", pc, 32'h0040_0400);
    check_val("live.src", {30'b0, src}, 32'h2);

    // Wrap from the top of the address space
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    step("wrap1");
    check_val("wrap1.plus", pc_plus, 32'h0000_0000);
    idle();
    step("wrap2");
    check_val("wrap.abs", pc, 32'h0000_0000);

    // Asynchronous reset mid-stall discards the buffer
    drive(1'b1, 1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b0, 32'h0);
    step("arst_stall");
    check_val("arst_pre.pvalid", {31'b0, pend_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_val("arst.pc", pc, 32'h0040_0000);
    check_val("arst.pvalid", {31'b0, pend_valid}, 32'h0);
    check_all("arst");
    idle();
    #1 rst = 1'b0;
    step("arst_rel");
    check_val("arst_rel.abs", pc, 32'h0040_0004);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), $urandom(),
            ($urandom_range(0, 4) == 0), $urandom(),
            ($urandom_range(0, 7) == 0), $urandom());
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rnd_rst");
        rst = 1'b0;
      end
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
